// File: rtl/iob_eth_rx_ring_if.sv
// Interface bundling the receive byte stream, CPU/DMA read port, and ring status.
// Parameters:
//   DATA_W       read word width (32 or 64)
//   FRAME_ADDR_W log2 of max bytes per slot
//   NSLOTS       number of frame slots (power of two)
//   CNT_W        overflow counter width
// Modports:
//   master : drives the stream, read and pop controls; observes data and status
//   slave  : the ring itself
interface iob_eth_rx_ring_if #(
  parameter int DATA_W       = 32,
  parameter int FRAME_ADDR_W = 11,
  parameter int NSLOTS       = 4,
  parameter int CNT_W        = 16
);
  localparam int BYTES  = DATA_W / 8;
  localparam int BYTE_W = $clog2(BYTES);
  localparam int SLOT_W = $clog2(NSLOTS);

  logic                           clear;
  logic                           in_valid;
  logic [7:0]                     in_data;
  logic                           in_last;
  logic                           in_crc_ok;
  logic [FRAME_ADDR_W-BYTE_W-1:0] rd_addr;
  logic                           rd_en;
  logic [DATA_W-1:0]              rd_data;
  logic                           head_valid;
  logic [FRAME_ADDR_W:0]          head_nbytes;
  logic                           head_crc_ok;
  logic                           pop;
  logic [SLOT_W:0]                count;
  logic [CNT_W-1:0]               overflow_cnt;
  logic                           drop;
  logic                           len_err;

  modport master (
    output clear, in_valid, in_data, in_last, in_crc_ok, rd_addr, rd_en, pop,
    input  rd_data, head_valid, head_nbytes, head_crc_ok, count, overflow_cnt,
           drop, len_err
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, in_crc_ok, rd_addr, rd_en, pop,
    output rd_data, head_valid, head_nbytes, head_crc_ok, count, overflow_cnt,
           drop, len_err
  );
endinterface

// File: rtl/iob_eth_rx_ring.sv
// Multi-frame Ethernet receive ring. Packs the received byte stream
// little-endian into DATA_W-bit words in one of NSLOTS frame slots, keeps
// per-slot length and CRC status, and lets the CPU/DMA read the oldest frame
// by word address and release it with pop.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  iob_eth_rx_ring_if.slave: byte stream in, read port, pop, status
//
// state | meaning
// IDLE  | waiting for the first byte of a frame
// RECV  | storing bytes of an accepted frame into the tail slot
// DROP  | discarding a frame (ring was full at its start, or abandoned by clear)
// TRUNC | discarding an oversize frame until its last byte
module iob_eth_rx_ring #(
  parameter int DATA_W       = 32,
  parameter int FRAME_ADDR_W = 11,
  parameter int NSLOTS       = 4,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst,
  iob_eth_rx_ring_if.slave bus
);
  localparam int BYTES   = DATA_W / 8;
  localparam int BYTE_W  = $clog2(BYTES);
  localparam int SLOT_W  = $clog2(NSLOTS);
  localparam int MEM_AW  = SLOT_W + FRAME_ADDR_W - BYTE_W;
  localparam logic [FRAME_ADDR_W:0] MAX_BYTES = (FRAME_ADDR_W+1)'(1) << FRAME_ADDR_W;
  localparam logic [SLOT_W:0]       FULL      = (SLOT_W+1)'(NSLOTS);

  typedef enum logic [1:0] {IDLE, RECV, DROP, TRUNC} state_t;

  state_t                state_q, state_d;
  logic [SLOT_W-1:0]     head_q, tail_q;
  logic [SLOT_W:0]       count_q;
  logic [FRAME_ADDR_W:0] byte_cnt_q, byte_cnt_d;
  logic                  abandon_q, abandon_d;
  logic [CNT_W-1:0]      ovf_q;
  logic                  drop_q, len_err_q;
  logic [DATA_W-1:0]     rd_data_q;

  logic [BYTES-1:0][7:0] mem [2**MEM_AW];
  logic [FRAME_ADDR_W:0] len_mem [NSLOTS];
  logic                  crc_mem [NSLOTS];

  logic                    wr_en, commit, drop_d, len_err_d, do_pop, full;
  logic [FRAME_ADDR_W-1:0] wr_byte;
  logic [FRAME_ADDR_W:0]   commit_len;

  assign full   = (count_q == FULL);
  assign do_pop = bus.pop && (count_q != '0) && !bus.clear;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    abandon_d  = abandon_q;
    wr_en      = 1'b0;
    wr_byte    = byte_cnt_q[FRAME_ADDR_W-1:0];
    commit     = 1'b0;
    commit_len = byte_cnt_q + 1'b1;
    drop_d     = 1'b0;
    len_err_d  = 1'b0;
    if (bus.clear) begin
      // An in-flight frame is abandoned silently; its tail is swallowed in DROP.
      if (state_q == RECV) begin
        state_d   = DROP;
        abandon_d = 1'b1;
      end
    end else if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (!full) begin
            wr_en   = 1'b1;
            wr_byte = '0;
            if (bus.in_last) begin
              commit     = 1'b1;
              commit_len = (FRAME_ADDR_W+1)'(1);
            end else begin
              byte_cnt_d = (FRAME_ADDR_W+1)'(1);
              state_d    = RECV;
            end
          end else if (bus.in_last) begin
            drop_d = 1'b1;
          end else begin
            state_d   = DROP;
            abandon_d = 1'b0;
          end
        end
        RECV: begin
          wr_en = 1'b1;
          if (bus.in_last) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            // Slot is full with no end in sight: everything else is oversize.
            if (byte_cnt_q + 1'b1 == MAX_BYTES) state_d = TRUNC;
          end
        end
        DROP: begin
          if (bus.in_last) begin
            drop_d  = !abandon_q;
            state_d = IDLE;
          end
        end
        TRUNC: begin
          if (bus.in_last) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      abandon_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= '0;
      drop_q     <= 1'b0;
      len_err_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      abandon_q  <= abandon_d;
      drop_q     <= drop_d;
      len_err_q  <= len_err_d;
      if (drop_d && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;
      if (bus.clear) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (commit) tail_q <= tail_q + 1'b1;
        if (do_pop) head_q <= head_q + 1'b1;
        if (commit && !do_pop)      count_q <= count_q + 1'b1;
        else if (!commit && do_pop) count_q <= count_q - 1'b1;
      end
      // Uses the pre-pop head when read and pop coincide.
      if (bus.rd_en) rd_data_q <= mem[{head_q, bus.rd_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{tail_q, wr_byte[FRAME_ADDR_W-1:BYTE_W]}][wr_byte[BYTE_W-1:0]] <= bus.in_data;
    if (commit) begin
      len_mem[tail_q] <= commit_len;
      crc_mem[tail_q] <= bus.in_crc_ok;
    end
  end

  assign bus.head_valid   = (count_q != '0);
  assign bus.head_nbytes  = bus.head_valid ? len_mem[head_q] : '0;
  assign bus.head_crc_ok  = bus.head_valid ? crc_mem[head_q] : 1'b0;
  assign bus.count        = count_q;
  assign bus.overflow_cnt = ovf_q;
  assign bus.drop         = drop_q;
  assign bus.len_err      = len_err_q;
  assign bus.rd_data      = rd_data_q;
endmodule

// File: tb/tb_iob_eth_rx_ring.sv
// Self-checking bench for iob_eth_rx_ring. A 32-bit and a 64-bit instance see
// identical stimulus; the 64-bit one has a 2-bit overflow counter so its
// saturation can be observed. A queue of expected frames models the ring.
module tb_iob_eth_rx_ring;
  localparam int FAW = 11;
  localparam int NS  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 0, in_valid = 0, in_last = 0, in_crc_ok = 0, rd_en = 0, pop = 0;
  logic [7:0] in_data = 0;
  logic [8:0] rd_addr32 = 0;
  logic [7:0] rd_addr64 = 0;

  iob_eth_rx_ring_if #(.DATA_W(32), .FRAME_ADDR_W(FAW), .NSLOTS(NS), .CNT_W(16)) b32 ();
  iob_eth_rx_ring_if #(.DATA_W(64), .FRAME_ADDR_W(FAW), .NSLOTS(NS), .CNT_W(2))  b64 ();

  assign b32.clear = clear;      assign b64.clear = clear;
  assign b32.in_valid = in_valid; assign b64.in_valid = in_valid;
  assign b32.in_data = in_data;  assign b64.in_data = in_data;
  assign b32.in_last = in_last;  assign b64.in_last = in_last;
  assign b32.in_crc_ok = in_crc_ok; assign b64.in_crc_ok = in_crc_ok;
  assign b32.rd_en = rd_en;      assign b64.rd_en = rd_en;
  assign b32.pop = pop;          assign b64.pop = pop;
  assign b32.rd_addr = rd_addr32; assign b64.rd_addr = rd_addr64;

  iob_eth_rx_ring #(.DATA_W(32), .FRAME_ADDR_W(FAW), .NSLOTS(NS), .CNT_W(16)) u32 (
    .clk(clk), .rst(rst), .bus(b32.slave));
  iob_eth_rx_ring #(.DATA_W(64), .FRAME_ADDR_W(FAW), .NSLOTS(NS), .CNT_W(2)) u64 (
    .clk(clk), .rst(rst), .bus(b64.slave));

  typedef struct {
    int         len;
    bit         crc;
    logic [7:0] seed;
  } frame_t;

  frame_t q[$];
  int     ovf_m   = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    int len_e;
    bit crc_e;
    len_e = 0;
    crc_e = 0;
    if (q.size() != 0) begin
      len_e = q[0].len;
      crc_e = q[0].crc;
    end
    chk({tag, ".valid"},  b32.head_valid,   q.size() != 0);
    chk({tag, ".nbytes"}, b32.head_nbytes,  len_e);
    chk({tag, ".crc"},    b32.head_crc_ok,  crc_e);
    chk({tag, ".count"},  b32.count,        q.size());
    chk({tag, ".ovf"},    b32.overflow_cnt, ovf_m);
    chk({tag, ".nb64"},   b64.head_nbytes,  len_e);
    chk({tag, ".cnt64"},  b64.count,        q.size());
    chk({tag, ".ovf64"},  b64.overflow_cnt, (ovf_m > 3) ? 3 : ovf_m);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"},  b32.head_valid,   0);
    chk({tag, ".nbytes"}, b32.head_nbytes,  0);
    chk({tag, ".crc"},    b32.head_crc_ok,  0);
    chk({tag, ".count"},  b32.count,        0);
    chk({tag, ".ovf"},    b32.overflow_cnt, 0);
    chk({tag, ".drop"},   b32.drop,         0);
    chk({tag, ".lenerr"}, b32.len_err,      0);
    chk({tag, ".rd"},     b32.rd_data,      0);
    chk({tag, ".rd64"},   b64.rd_data,      0);
    chk({tag, ".ovf64"},  b64.overflow_cnt, 0);
  endtask

  task automatic send_frame(input int len, input logic [7:0] seed, input bit crc,
                            input bit pop_last);
    bit accept;
    accept = q.size() < NS;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      in_valid  = 1;
      in_data   = seed + 8'(k);
      in_last   = (k == len - 1);
      in_crc_ok = crc && (k == len - 1);
      pop       = pop_last && (k == len - 1);
    end
    @(negedge clk);
    in_valid = 0; in_last = 0; in_crc_ok = 0; pop = 0;
    if (pop_last && q.size() != 0) void'(q.pop_front());
    if (accept && len <= (1 << FAW)) q.push_back('{len, crc, seed});
    if (!accept) ovf_m++;
    chk("drop",   b32.drop,    !accept);
    chk("drop64", b64.drop,    !accept);
    chk("lenerr", b32.len_err, accept && len > (1 << FAW));
  endtask

  task automatic read_word(input int w, output logic [31:0] d32, output logic [63:0] d64);
    @(negedge clk);
    rd_en = 1; rd_addr32 = 9'(w); rd_addr64 = 8'(w / 2);
    @(negedge clk);
    rd_en = 0;
    d32 = b32.rd_data;
    d64 = b64.rd_data;
  endtask

  task automatic read_check_frame(input string tag);
    frame_t      f;
    logic [31:0] d32, e32, m32;
    logic [63:0] d64;
    logic [7:0]  bv;
    if (q.size() == 0) begin
      chk({tag, ".nonempty"}, b32.head_valid, 1);
      return;
    end
    f = q[0];
    for (int w = 0; w < (f.len + 3) / 4; w++) begin
      read_word(w, d32, d64);
      e32 = 0; m32 = 0;
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < f.len) begin
          bv = f.seed + 8'(w * 4 + b);
          e32[8*b +: 8] = bv;
          m32[8*b +: 8] = 8'hFF;
        end
      end
      chk({tag, ".rd32"}, d32 & m32, e32);
      chk({tag, ".rd64"}, d64[32*(w%2) +: 32] & m32, e32);
    end
    @(negedge clk); pop = 1;
    @(negedge clk); pop = 0;
    void'(q.pop_front());
    check_head({tag, ".pop"});
  endtask

  logic [31:0] r32;
  logic [63:0] r64;

  initial begin
    // Reset state
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1;

    // Test 1: 64-byte frame 0x00..0x3F
    send_frame(64, 8'h00, 1, 0);
    check_head("t1");
    read_word(0, r32, r64);
    chk("t1.w0", r32, 32'h03020100);
    read_word(15, r32, r64);
    chk("t1.w15", r32, 32'h3F3E3D3C);
    chk("t1.w7_64", r64, 64'h3F3E3D3C3B3A3938);
    read_check_frame("t1");

    // Test 2: five 60-byte frames, no pops
    for (int i = 0; i < 5; i++) begin
      send_frame(60, 8'(10 * (i + 1)), (i % 2) == 0, 0);
      check_head("t2");
    end
    read_check_frame("t2");
    read_check_frame("t2b");

    // Test 3: two frames held, pop coincides with last byte of a third
    send_frame(33, 8'h77, 1, 1);
    check_head("t3");

    // Fill the ring and keep dropping to saturate the narrow counter
    send_frame(7, 8'h21, 0, 0);
    send_frame(13, 8'h42, 1, 0);
    for (int i = 0; i < 3; i++) send_frame(5, 8'h90, 1, 0);
    check_head("sat");
    for (int i = 0; i < 4; i++) read_check_frame("drain");

    // Clear with a committed frame held and another mid-reception
    send_frame(30, 8'h55, 1, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); in_valid = 1; in_data = 8'(k); in_last = 0;
    end
    @(negedge clk); in_valid = 0; clear = 1;
    @(negedge clk); clear = 0;
    q.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); in_valid = 1; in_data = 8'(k); in_last = (k == 4);
    end
    @(negedge clk); in_valid = 0; in_last = 0;
    chk("clr.drop", b32.drop, 0);
    check_head("clr");

    // Test 4: oversize and exact-max frames
    send_frame(2049, 8'h11, 1, 0);
    check_head("t4.trunc");
    send_frame(100, 8'h22, 1, 0);
    check_head("t4.100");
    read_check_frame("t4.100");
    send_frame(2048, 8'h33, 0, 0);
    check_head("t4.2048");
    read_check_frame("t4.2048");

    // Test 6: lengths 1..10 through a 4-slot ring
    for (int l = 1; l <= 10; l++) begin
      send_frame(l, 8'(l * 7), (l % 2) == 1, 0);
      check_head("t6");
      read_check_frame("t6");
    end

    // Test 5: reset mid-frame
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); in_valid = 1; in_data = 8'(k); in_last = 0;
    end
    @(negedge clk); in_valid = 0; rst = 0;
    #1;
    check_zero("t5.rst");
    @(negedge clk); rst = 1;
    q.delete();
    ovf_m = 0;
    send_frame(1, 8'hA5, 1, 0);
    check_head("t5");
    read_word(0, r32, r64);
    chk("t5.rd", r32[7:0], 8'hA5);
    chk("t5.rd64", r64[7:0], 8'hA5);
    read_check_frame("t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
